mmio_io_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller for the single-cycle CPU data bus; replaces ad-hoc HEX/LEDR/KEY/SW decode in the top level.
- Adds what the first-generation I/O lacked:
  - width-generic HEX, LEDR, KEY and SW;
  - switch debouncing;
  - sticky ready/overrun status with interrupt enables;
  - a programmable interval timer.
- Sits beside data memory; the CPU muxes `rdata` when `hit`=1.

---
 rtl/io_pkg.sv | 81 ++++++++
 rtl/mmio_io_ctrl_if.sv | 13 +
 rtl/io_sync_debounce.sv | 45 ++++
 rtl/mmio_io_ctrl.sv | 131 +++++++++++++
 tb/tb_mmio_io_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O controller: register offsets,
// status bit layout, address decode selector and the 7-segment decoder.
package io_pkg;

  localparam logic [11:0] OFF_HEX   = 12'h000;
  localparam logic [11:0] OFF_LEDR  = 12'h004;
  localparam logic [11:0] OFF_KDATA = 12'h010;
  localparam logic [11:0] OFF_SDATA = 12'h014;
  localparam logic [11:0] OFF_TCNT  = 12'h020;
  localparam logic [11:0] OFF_TLIM  = 12'h024;
  localparam logic [11:0] OFF_KCTRL = 12'h110;
  localparam logic [11:0] OFF_SCTRL = 12'h114;
  localparam logic [11:0] OFF_TCTL  = 12'h120;

  localparam int RDY = 0;
  localparam int OVR = 1;
  localparam int IE  = 4;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_HEX, SEL_LEDR, SEL_KDATA, SEL_SDATA,
    SEL_TCNT, SEL_TLIM, SEL_KCTRL, SEL_SCTRL, SEL_TCTL
  } sel_e;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic rdy;
  } stat_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [4:0] stat_word(input stat_t s);
    logic [4:0] w;
    w      = '0;
    w[RDY] = s.rdy;
    w[OVR] = s.ovr;
    w[IE]  = s.ie;
    return w;
  endfunction

  // An event landing together with a ready clear wins: ready stays set and
  // the clear does not count as a missed event.
  function automatic stat_t stat_next(input stat_t s, input logic evt,
                                      input logic rd_clr, input logic wr,
                                      input logic [4:0] w, input logic rdy_writable);
    stat_t n;
    logic  clr;
    n   = s;
    clr = rd_clr | (wr & rdy_writable & ~w[RDY]);
    if (wr) begin
      n.ie = w[IE];
      if (!w[OVR]) n.ovr = 1'b0;
    end
    if (clr) n.rdy = 1'b0;
    if (evt) begin
      n.rdy = 1'b1;
      if (s.rdy && !clr) n.ovr = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU data-bus view of the I/O page: address/data/strobes from the CPU,
// combinational hit and load data back.
interface mmio_io_ctrl_if #(parameter int DBITS = 32);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic             hit;
  logic [DBITS-1:0] rdata;

  modport master (output addr, wdata, we, re, input hit, rdata);
  modport slave  (input addr, wdata, we, re, output hit, rdata);
endinterface

// File: rtl/io_sync_debounce.sv
// Two-flop synchroniser followed by a stability filter; CYCLES=0 degenerates
// to a plain synchroniser with a registered output.
module io_sync_debounce #(
  parameter int               WIDTH   = 1,
  parameter int               CYCLES  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] value,
  output logic             changed
);
  localparam int            CW   = $clog2(CYCLES + 2);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES);

  logic [WIDTH-1:0] s1, s2, cand;
  logic [CW-1:0]    cnt, cnt_next;
  logic             load;

  // cnt holds how many consecutive cycles s2 has matched cand, saturating.
  always_comb begin
    if (s2 != cand)        cnt_next = CW'(1);
    else if (cnt == CMAX)  cnt_next = CMAX;
    else                   cnt_next = cnt + 1'b1;
    load    = (CYCLES == 0) || (cnt_next == CMAX);
    changed = load && (s2 != value);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= RST_VAL;
      s2    <= RST_VAL;
      cand  <= RST_VAL;
      value <= RST_VAL;
      cnt   <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      cand <= s2;
      cnt  <= cnt_next;
      if (load) value <= s2;
    end
  end
endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O page: HEX/LEDR outputs, synchronised KEY, debounced SW,
// interval timer, each with sticky ready/overrun status and interrupt enable.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] IO_BASE         = 32'hF0000000,
  parameter int               HEX_DIGITS      = 4,
  parameter int               LEDR_BITS       = 10,
  parameter int               KEY_BITS        = 4,
  parameter int               SW_BITS         = 10,
  parameter int               DEBOUNCE_CYCLES = 100000,
  parameter int               TICK_CYCLES     = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mmio_io_ctrl_if.slave           bus,
  input  logic [KEY_BITS-1:0]     key_in,
  input  logic [SW_BITS-1:0]      sw_in,
  output logic [7*HEX_DIGITS-1:0] hex_out,
  output logic [LEDR_BITS-1:0]    ledr_out,
  output logic                    irq
);
  localparam int            HW    = 4 * HEX_DIGITS;
  localparam int            PW    = $clog2(TICK_CYCLES + 1);
  localparam logic [PW-1:0] PLAST = PW'(TICK_CYCLES - 1);

  sel_e                 sel;
  logic [HW-1:0]        hex_reg;
  logic [LEDR_BITS-1:0] ledr_reg;
  logic [KEY_BITS-1:0]  key_sync;
  logic [SW_BITS-1:0]   sdata;
  logic                 key_evt, sw_evt;
  stat_t                kst, sst, tst;
  logic [DBITS-1:0]     tcnt, tlim;
  logic [PW-1:0]        presc;
  logic                 tick, t_evt, wr_tcnt, wr_tlim;

  io_sync_debounce #(.WIDTH(KEY_BITS), .CYCLES(0), .RST_VAL('1)) u_key (
    .clk(clk), .reset_n(reset_n), .raw(key_in), .value(key_sync), .changed(key_evt)
  );

  io_sync_debounce #(.WIDTH(SW_BITS), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL('0)) u_sw (
    .clk(clk), .reset_n(reset_n), .raw(sw_in), .value(sdata), .changed(sw_evt)
  );

  always_comb begin
    sel = SEL_NONE;
    if (bus.addr[DBITS-1:12] == IO_BASE[DBITS-1:12]) begin
      case (bus.addr[11:0])
        OFF_HEX:   sel = SEL_HEX;
        OFF_LEDR:  sel = SEL_LEDR;
        OFF_KDATA: sel = SEL_KDATA;
        OFF_SDATA: sel = SEL_SDATA;
        OFF_TCNT:  sel = SEL_TCNT;
        OFF_TLIM:  sel = SEL_TLIM;
        OFF_KCTRL: sel = SEL_KCTRL;
        OFF_SCTRL: sel = SEL_SCTRL;
        OFF_TCTL:  sel = SEL_TCTL;
        default:   sel = SEL_NONE;
      endcase
    end
  end

  assign bus.hit = (sel != SEL_NONE);

  always_comb begin
    bus.rdata = '0;
    case (sel)
      SEL_HEX:   bus.rdata[HW-1:0]        = hex_reg;
      SEL_LEDR:  bus.rdata[LEDR_BITS-1:0] = ledr_reg;
      SEL_KDATA: bus.rdata[KEY_BITS-1:0]  = ~key_sync;
      SEL_SDATA: bus.rdata[SW_BITS-1:0]   = sdata;
      SEL_TCNT:  bus.rdata                = tcnt;
      SEL_TLIM:  bus.rdata                = tlim;
      SEL_KCTRL: bus.rdata[4:0]           = stat_word(kst);
      SEL_SCTRL: bus.rdata[4:0]           = stat_word(sst);
      SEL_TCTL:  bus.rdata[4:0]           = stat_word(tst);
      default:   bus.rdata                = '0;
    endcase
  end

  // A register write takes priority over a tick landing in the same cycle.
  always_comb begin
    wr_tcnt = bus.we && (sel == SEL_TCNT);
    wr_tlim = bus.we && (sel == SEL_TLIM);
    tick    = (presc == PLAST);
    t_evt   = tick && !wr_tcnt && !wr_tlim && (tlim != '0) && (tcnt == tlim - 1'b1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_reg  <= '0;
      ledr_reg <= '0;
      kst      <= '0;
      sst      <= '0;
      tst      <= '0;
      tcnt     <= '0;
      tlim     <= '0;
      presc    <= '0;
    end else begin
      if (bus.we && (sel == SEL_HEX))  hex_reg  <= bus.wdata[HW-1:0];
      if (bus.we && (sel == SEL_LEDR)) ledr_reg <= bus.wdata[LEDR_BITS-1:0];
      kst <= stat_next(kst, key_evt, bus.re && (sel == SEL_KDATA),
                       bus.we && (sel == SEL_KCTRL), bus.wdata[4:0], 1'b0);
      sst <= stat_next(sst, sw_evt, bus.re && (sel == SEL_SDATA),
                       bus.we && (sel == SEL_SCTRL), bus.wdata[4:0], 1'b0);
      tst <= stat_next(tst, t_evt, 1'b0,
                       bus.we && (sel == SEL_TCTL), bus.wdata[4:0], 1'b1);
      if (wr_tlim) begin
        tlim  <= bus.wdata;
        tcnt  <= '0;
        presc <= '0;
      end else if (wr_tcnt) begin
        tcnt  <= bus.wdata;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) tcnt <= t_evt ? '0 : tcnt + 1'b1;
      end
    end
  end

  for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_hex
    assign hex_out[7*d +: 7] = hex7(hex_reg[4*d +: 4]);
  end

  assign ledr_out = ledr_reg;
  assign irq      = (kst.rdy & kst.ie) | (sst.rdy & sst.ie) | (tst.rdy & tst.ie);

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: register vector table plus hand-timed
// sequences for key, switch debounce, timer and asynchronous reset.
module tb_mmio_io_ctrl;
  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_SDATA = 32'hF0000014;
  localparam logic [31:0] A_TCNT  = 32'hF0000020;
  localparam logic [31:0] A_TLIM  = 32'hF0000024;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;
  localparam logic [31:0] A_TCTL  = 32'hF0000120;
  localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [27:0] hex_out;
  logic [9:0]  ledr_out;
  logic        irq;
  int          vectors;
  int          miscompares;
  vec_t        tv[18];

  mmio_io_ctrl_if #(.DBITS(32)) bus ();

  mmio_io_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .key_in(key_in), .sw_in(sw_in),
    .hex_out(hex_out), .ledr_out(ledr_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.addr = a;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    #1;
    d = bus.rdata;
    h = bus.hit;
  endtask

  task automatic pchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    peek(a, d, h);
    chk(nm, d, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.re    = 1'b0;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b0;
    bus.re   = 1'b1;
    @(negedge clk);
    d = bus.rdata;
    @(posedge clk);
    #1;
    bus.re = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        h;

    tv[0]  = '{A_HEX,         32'h00001234, 1'b1, 1'b1, 32'h00001234};
    tv[1]  = '{A_LEDR,        32'hFFFFFFFF, 1'b1, 1'b1, 32'h000003FF};
    tv[2]  = '{A_LEDR,        32'h000002A5, 1'b1, 1'b1, 32'h000002A5};
    tv[3]  = '{32'hF0000018,  32'h0000DEAD, 1'b1, 1'b0, 32'h0};
    tv[4]  = '{32'hE0000004,  32'h00000123, 1'b1, 1'b0, 32'h0};
    tv[5]  = '{A_LEDR,        32'h0,        1'b0, 1'b1, 32'h000002A5};
    tv[6]  = '{A_HEX,         32'h0,        1'b0, 1'b1, 32'h00001234};
    tv[7]  = '{A_TLIM,        32'h00000007, 1'b1, 1'b1, 32'h00000007};
    tv[8]  = '{A_TLIM,        32'h00000000, 1'b1, 1'b1, 32'h0};
    tv[9]  = '{A_KCTRL,       32'h0,        1'b0, 1'b1, 32'h0};
    tv[10] = '{A_SCTRL,       32'h00000013, 1'b1, 1'b1, 32'h00000010};
    tv[11] = '{A_SCTRL,       32'h00000000, 1'b1, 1'b1, 32'h0};
    tv[12] = '{A_TCTL,        32'h0000001F, 1'b1, 1'b1, 32'h00000010};
    tv[13] = '{A_TCTL,        32'h00000000, 1'b1, 1'b1, 32'h0};
    tv[14] = '{32'hF0000100,  32'h0,        1'b0, 1'b0, 32'h0};
    tv[15] = '{32'hF0001000,  32'h0,        1'b0, 1'b0, 32'h0};
    tv[16] = '{A_SDATA,       32'h0,        1'b0, 1'b1, 32'h0};
    tv[17] = '{A_KDATA,       32'h0,        1'b0, 1'b1, 32'h0};

    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    key_in      = 4'b1111;
    sw_in       = '0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_hex_out", 32'(hex_out), 32'(HEX_ZERO));
    chk("rst_ledr", 32'(ledr_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    for (int unsigned i = 0; i < 18; i++) begin
      if (tv[i].we) bus_write(tv[i].addr, tv[i].wdata);
      peek(tv[i].addr, d, h);
      chk($sformatf("vec%0d_hit", i), 32'(h), 32'(tv[i].exp_hit));
      chk($sformatf("vec%0d_rdata", i), d, tv[i].exp_rdata);
      idle();
    end
    chk("hex_out_1234", 32'(hex_out),
        32'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
    chk("hex_digit0", 32'(hex_out[6:0]), 32'(7'b0011001));
    chk("hex_digit3", 32'(hex_out[27:21]), 32'(7'b1111001));
    chk("ledr_out", 32'(ledr_out), 32'h2A5);

    // KEY: synced data appears on the third edge, status with it
    key_in = 4'b1110;
    idle();
    idle();
    pchk("kdata_before", A_KDATA, 32'h0);
    idle();
    pchk("kdata_after3", A_KDATA, 32'h1);
    pchk("kctrl_ready", A_KCTRL, 32'h1);
    key_in = 4'b1100;
    repeat (3) idle();
    pchk("kdata_second", A_KDATA, 32'h3);
    pchk("kctrl_overrun", A_KCTRL, 32'h3);
    bus_read(A_KDATA, d);
    chk("kdata_read", d, 32'h3);
    pchk("kctrl_after_read", A_KCTRL, 32'h2);
    bus_write(A_KCTRL, 32'h10);
    pchk("kctrl_ie_write", A_KCTRL, 32'h10);
    chk("irq_key_not_ready", 32'(irq), 32'h0);
    bus_write(A_KCTRL, 32'h0);

    // KDATA read commits on the same edge as a new key event
    key_in = 4'b1110;
    idle();
    idle();
    bus_read(A_KDATA, d);
    chk("kdata_coinc_read", d, 32'h3);
    pchk("kctrl_coinc", A_KCTRL, 32'h1);
    bus_read(A_KDATA, d);
    chk("kdata_coinc_val", d, 32'h1);
    pchk("kctrl_cleared", A_KCTRL, 32'h0);

    // SW: 2 sync edges + 4 stable cycles before SDATA follows
    sw_in = 10'h155;
    repeat (5) idle();
    pchk("sdata_early", A_SDATA, 32'h0);
    idle();
    pchk("sdata_loaded", A_SDATA, 32'h155);
    pchk("sctrl_ready", A_SCTRL, 32'h1);
    sw_in = 10'h154;
    idle();
    idle();
    sw_in = 10'h155;
    for (int unsigned i = 0; i < 10; i++) begin
      idle();
      pchk($sformatf("sdata_glitch%0d", i), A_SDATA, 32'h155);
    end
    pchk("sctrl_glitch", A_SCTRL, 32'h1);
    bus_read(A_SDATA, d);
    chk("sdata_read", d, 32'h155);
    pchk("sctrl_cleared", A_SCTRL, 32'h0);

    // Timer: limit 3, tick every 3 cycles -> event 9 cycles after the TLIM write
    bus_write(A_TCTL, 32'h10);
    bus_write(A_TLIM, 32'h3);
    for (int unsigned i = 1; i <= 9; i++) begin
      idle();
      chk($sformatf("tmr_irq_c%0d", i), 32'(irq), 32'(i == 9));
      peek(A_TCTL, d, h);
      chk($sformatf("tmr_rdy_c%0d", i), d & 32'h1, 32'(i == 9));
    end
    pchk("tcnt_wrapped", A_TCNT, 32'h0);
    bus_write(A_TCTL, 32'h10);
    pchk("tctl_clear", A_TCTL, 32'h10);
    chk("irq_cleared", 32'(irq), 32'h0);
    for (int unsigned i = 11; i <= 18; i++) begin
      idle();
      peek(A_TCTL, d, h);
      chk($sformatf("tmr2_rdy_c%0d", i), d & 32'h1, 32'(i == 18));
    end
    chk("irq_second", 32'(irq), 32'h1);
    bus_write(A_TCTL, 32'h0);
    bus_write(A_TLIM, 32'h0);
    repeat (15) idle();
    pchk("tcnt_free_run", A_TCNT, 32'h5);
    pchk("tctl_no_event", A_TCTL, 32'h0);
    idle();
    idle();
    bus_write(A_TCNT, 32'h100);
    pchk("tcnt_write_vs_tick", A_TCNT, 32'h100);
    repeat (3) idle();
    pchk("tcnt_after_tick", A_TCNT, 32'h101);

    // Asynchronous reset between clock edges
    idle();
    reset_n = 1'b0;
    #1;
    chk("areset_hex_out", 32'(hex_out), 32'(HEX_ZERO));
    chk("areset_ledr", 32'(ledr_out), 32'h0);
    chk("areset_irq", 32'(irq), 32'h0);
    pchk("areset_tcnt", A_TCNT, 32'h0);
    pchk("areset_sdata", A_SDATA, 32'h0);
    pchk("areset_hex", A_HEX, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
